// File: rtl/fechadura_pkg.sv
// rtl/fechadura_pkg.sv - shared password buffer type, key codes and FSM states
package fechadura_pkg;

  localparam int unsigned N_DIGITOS_PAC = 20;

  typedef struct packed {
    logic [N_DIGITOS_PAC-1:0][3:0] digits;
  } senhaPac_t;

  localparam logic [3:0] TECLA_LIMPA  = 4'hA;
  localparam logic [3:0] TECLA_ENVIA  = 4'hB;
  localparam logic [3:0] DIGITO_VAZIO = 4'hF;

  localparam senhaPac_t SENHA_VAZIA = senhaPac_t'({N_DIGITOS_PAC{DIGITO_VAZIO}});

  typedef enum logic [2:0] {
    IDLE,
    COLETANDO,
    ENVIANDO,
    AGUARDANDO,
    RESULTADO
  } estado_t;

  function automatic logic eh_digito(input logic [3:0] k);
    return k <= 4'h9;
  endfunction

endpackage

// File: rtl/buffer_digitos.sv
// rtl/buffer_digitos.sv - digit buffer that fills oldest-first, then slides a window once full
module buffer_digitos
  import fechadura_pkg::*;
#(
  parameter int unsigned N_DIGITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [3:0] din,
  output logic       full,
  output logic [4:0] count,
  output senhaPac_t  dout
);

  senhaPac_t  buf_q;
  logic [4:0] count_q;

  assign full  = (count_q == 5'(N_DIGITS));
  assign count = count_q;
  assign dout  = buf_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      buf_q   <= SENHA_VAZIA;
      count_q <= '0;
    end else if (wr_en) begin
      if (full) begin
        // keep the most recent N_DIGITS keys: drop digits[0], append at the top
        for (int i = 0; i < int'(N_DIGITS) - 1; i++) begin
          buf_q.digits[i] <= buf_q.digits[i+1];
        end
        buf_q.digits[N_DIGITS-1] <= din;
      end else begin
        buf_q.digits[count_q] <= din;
        count_q               <= count_q + 5'd1;
      end
    end
  end

endmodule

// File: rtl/monta_senha.sv
// rtl/monta_senha.sv - collects keypad digits, submits them to the verifier and reports the verdict
module monta_senha
  import fechadura_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 20,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned WAIT_MAX       = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output senhaPac_t  senha_real,
  output logic       senha_valid,
  input  logic       done,
  input  logic       senha_ok,
  output logic       acesso_ok,
  output logic       acesso_negado,
  output logic       ocupado,
  output logic [4:0] n_digitos
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  estado_t           estado_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [WAIT_W-1:0] espera_q;
  logic [WAIT_W-1:0] espera_d;
  logic              senha_valid_q;
  logic              acesso_ok_q;
  logic              acesso_negado_q;
  logic              ocupado_q;

  logic tecla_dig;
  logic tecla_limpa;
  logic tecla_envia;
  logic tecla_aceita;
  logic tmo_fim;
  logic buf_clr;
  logic buf_wr;
  logic buf_cheio;

  assign tecla_dig    = key_valid && eh_digito(key_code);
  assign tecla_limpa  = key_valid && (key_code == TECLA_LIMPA);
  assign tecla_envia  = key_valid && (key_code == TECLA_ENVIA);
  assign tecla_aceita = tecla_dig || tecla_limpa || tecla_envia;
  assign tmo_fim      = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign espera_d     = espera_q + 1'b1;

  // buffer writes only while collecting; it stays frozen from ENVIANDO until RESULTADO ends
  always_comb begin
    buf_clr = 1'b0;
    buf_wr  = 1'b0;
    case (estado_q)
      IDLE: buf_wr = tecla_dig;
      COLETANDO: begin
        buf_wr  = tecla_dig;
        buf_clr = tecla_limpa || (!tecla_aceita && tmo_fim);
      end
      RESULTADO: buf_clr = 1'b1;
      default: ;
    endcase
  end

  buffer_digitos #(
    .N_DIGITS (N_DIGITS)
  ) u_buffer (
    .clk   (clk),
    .rst   (rst),
    .clr   (buf_clr),
    .wr_en (buf_wr),
    .din   (key_code),
    .full  (buf_cheio),
    .count (n_digitos),
    .dout  (senha_real)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (buf_cheio == (n_digitos == 5'(N_DIGITS)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q        <= IDLE;
      tmo_q           <= '0;
      espera_q        <= '0;
      senha_valid_q   <= 1'b0;
      acesso_ok_q     <= 1'b0;
      acesso_negado_q <= 1'b0;
      ocupado_q       <= 1'b0;
    end else begin
      senha_valid_q   <= 1'b0;
      acesso_ok_q     <= 1'b0;
      acesso_negado_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          tmo_q <= '0;
          if (tecla_dig) estado_q <= COLETANDO;
        end
        COLETANDO: begin
          if (tecla_aceita)         tmo_q <= '0;
          else if (tmo_q != TMO_MAX) tmo_q <= tmo_q + 1'b1;
          if (tecla_envia) begin
            estado_q      <= ENVIANDO;
            senha_valid_q <= 1'b1;
            ocupado_q     <= 1'b1;
          end else if (tecla_limpa || (!tecla_aceita && tmo_fim)) begin
            estado_q <= IDLE;
          end
        end
        ENVIANDO: begin
          estado_q <= AGUARDANDO;
          espera_q <= '0;
        end
        AGUARDANDO: begin
          espera_q <= espera_d;
          // done has priority over the wait limit expiring in the same cycle
          if (done) begin
            estado_q        <= RESULTADO;
            acesso_ok_q     <= senha_ok;
            acesso_negado_q <= !senha_ok;
          end else if (espera_d == WAIT_W'(WAIT_MAX)) begin
            estado_q        <= RESULTADO;
            acesso_negado_q <= 1'b1;
          end
        end
        RESULTADO: begin
          estado_q  <= IDLE;
          ocupado_q <= 1'b0;
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign senha_valid   = senha_valid_q;
  assign acesso_ok     = acesso_ok_q;
  assign acesso_negado = acesso_negado_q;
  assign ocupado       = ocupado_q;

endmodule

// File: tb/tb_monta_senha.sv
// tb/tb_monta_senha.sv - directed table and sequence bench for monta_senha
module tb_monta_senha;
  import fechadura_pkg::*;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code  = 4'h0;
  logic       done      = 1'b0;
  logic       senha_ok  = 1'b0;
  senhaPac_t  senha_real;
  logic       senha_valid;
  logic       acesso_ok;
  logic       acesso_negado;
  logic       ocupado;
  logic [4:0] n_digitos;

  int tests = 0;
  int fails = 0;
  int n_sv  = 0;
  int n_ok  = 0;
  int n_neg = 0;

  monta_senha #(
    .N_DIGITS       (20),
    .TIMEOUT_CYCLES (10),
    .WAIT_MAX       (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .senha_real    (senha_real),
    .senha_valid   (senha_valid),
    .done          (done),
    .senha_ok      (senha_ok),
    .acesso_ok     (acesso_ok),
    .acesso_negado (acesso_negado),
    .ocupado       (ocupado),
    .n_digitos     (n_digitos)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (senha_valid)   n_sv++;
    if (acesso_ok)     n_ok++;
    if (acesso_negado) n_neg++;
  end

  typedef struct {
    logic       kv;
    logic [3:0] kc;
    logic [4:0] n;
    logic [3:0] d0;
    logic       sv;
    logic       ocup;
  } vetor_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nome, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nome, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
  endtask

  function automatic senhaPac_t pac(input int n, input logic [3:0] a, b, c, d);
    logic [3:0] v [4];
    senhaPac_t  p;
    p = SENHA_VAZIA;
    v = '{a, b, c, d};
    for (int i = 0; i < n; i++) p.digits[i] = v[i];
    return p;
  endfunction

  // verifier model: accepts only the secret 1,2,3,4
  task automatic responde(input int atraso);
    senhaPac_t snap;
    logic      estavel;
    snap    = senha_real;
    estavel = 1'b1;
    repeat (atraso) begin
      tick();
      if (senha_real !== snap) estavel = 1'b0;
    end
    check("buffer estavel na espera", estavel, 1'b1);
    done     = 1'b1;
    senha_ok = (snap == pac(4, 4'h1, 4'h2, 4'h3, 4'h4));
    tick();
    done     = 1'b0;
    senha_ok = 1'b0;
  endtask

  task automatic confere(input logic ok_exp, input int ok0, input int neg0, input int sv0);
    check("pulso acesso_ok", acesso_ok, ok_exp);
    check("pulso acesso_negado", acesso_negado, !ok_exp);
    tick();
    check("n_digitos apos resultado", n_digitos, 0);
    check("ocupado apos resultado", ocupado, 0);
    check("buffer limpo apos resultado", senha_real, SENHA_VAZIA);
    check("contagem acesso_ok", n_ok - ok0, ok_exp ? 1 : 0);
    check("contagem acesso_negado", n_neg - neg0, ok_exp ? 0 : 1);
    check("contagem senha_valid", n_sv - sv0, 1);
  endtask

  initial begin
    vetor_t     tab [10];
    logic [3:0] seq [22];
    senhaPac_t  esp;
    int         ok0, neg0, sv0, primeiro;
    logic       estavel;

    tab[0] = '{1'b1, 4'hC, 5'd0, 4'hF, 1'b0, 1'b0};
    tab[1] = '{1'b1, 4'hA, 5'd0, 4'hF, 1'b0, 1'b0};
    tab[2] = '{1'b1, 4'hB, 5'd0, 4'hF, 1'b0, 1'b0};
    tab[3] = '{1'b1, 4'h5, 5'd1, 4'h5, 1'b0, 1'b0};
    tab[4] = '{1'b1, 4'h6, 5'd2, 4'h5, 1'b0, 1'b0};
    tab[5] = '{1'b1, 4'hE, 5'd2, 4'h5, 1'b0, 1'b0};
    tab[6] = '{1'b1, 4'hA, 5'd0, 4'hF, 1'b0, 1'b0};
    tab[7] = '{1'b1, 4'h9, 5'd1, 4'h9, 1'b0, 1'b0};
    tab[8] = '{1'b0, 4'h3, 5'd1, 4'h9, 1'b0, 1'b0};
    tab[9] = '{1'b1, 4'hB, 5'd1, 4'h9, 1'b1, 1'b1};

    // reset values
    repeat (2) tick();
    check("reset senha_real", senha_real, SENHA_VAZIA);
    check("reset n_digitos", n_digitos, 0);
    check("reset ocupado", ocupado, 0);
    check("reset senha_valid", senha_valid, 0);
    check("reset acesso_ok", acesso_ok, 0);
    check("reset acesso_negado", acesso_negado, 0);
    rst = 1'b0;
    tick();

    // basic accept
    ok0 = n_ok; neg0 = n_neg; sv0 = n_sv;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("basico n_digitos", n_digitos, 4);
    press(TECLA_ENVIA);
    check("basico senha_valid", senha_valid, 1);
    check("basico ocupado", ocupado, 1);
    check("basico buffer", senha_real, pac(4, 4'h1, 4'h2, 4'h3, 4'h4));
    responde(3);
    confere(1'b1, ok0, neg0, sv0);

    // clear key and ignored keys, table driven
    ok0 = n_ok; neg0 = n_neg; sv0 = n_sv;
    for (int i = 0; i < 10; i++) begin
      key_valid = tab[i].kv;
      key_code  = tab[i].kc;
      tick();
      key_valid = 1'b0;
      check($sformatf("tab%0d n_digitos", i), n_digitos, tab[i].n);
      check($sformatf("tab%0d digito0", i), senha_real.digits[0], tab[i].d0);
      check($sformatf("tab%0d senha_valid", i), senha_valid, tab[i].sv);
      check($sformatf("tab%0d ocupado", i), ocupado, tab[i].ocup);
    end
    check("limpa buffer enviado", senha_real, pac(1, 4'h9, 4'hF, 4'hF, 4'hF));
    responde(2);
    confere(1'b0, ok0, neg0, sv0);

    // overflow: window keeps the last 20 digits
    ok0 = n_ok; neg0 = n_neg; sv0 = n_sv;
    for (int i = 0; i < 22; i++) begin
      seq[i] = (i < 20) ? 4'(i % 10) : ((i == 20) ? 4'h7 : 4'h8);
      press(seq[i]);
      if (i == 19) check("overflow n_digitos cheio", n_digitos, 20);
    end
    check("overflow n_digitos", n_digitos, 20);
    for (int k = 0; k < 20; k++) esp.digits[k] = seq[k+2];
    press(TECLA_ENVIA);
    check("overflow senha_valid", senha_valid, 1);
    check("overflow buffer", senha_real, esp);
    check("overflow digito0", senha_real.digits[0], 4'h2);
    check("overflow digito19", senha_real.digits[19], 4'h8);
    responde(1);
    confere(1'b0, ok0, neg0, sv0);

    // inactivity timeout
    ok0 = n_ok; neg0 = n_neg; sv0 = n_sv;
    press(4'h3);
    repeat (9) tick();
    check("timeout antes do limite", n_digitos, 1);
    tick();
    check("timeout n_digitos", n_digitos, 0);
    check("timeout buffer", senha_real, SENHA_VAZIA);
    press(TECLA_ENVIA);
    check("timeout envia ignorado", senha_valid, 0);
    check("timeout ocupado", ocupado, 0);
    tick();
    check("timeout sem pulsos", (n_ok - ok0) + (n_neg - neg0) + (n_sv - sv0), 0);

    // done arriving in the last wait cycle wins over the forced fail
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    press(TECLA_ENVIA);
    repeat (8) tick();
    done = 1'b1; senha_ok = 1'b1;
    tick();
    done = 1'b0; senha_ok = 1'b0;
    check("done vence WAIT_MAX ok", acesso_ok, 1);
    check("done vence WAIT_MAX negado", acesso_negado, 0);
    tick();

    // busy: keys dropped, verifier silent, forced fail after WAIT_MAX
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    ok0 = n_ok; neg0 = n_neg;
    press(TECLA_ENVIA);
    estavel  = 1'b1;
    primeiro = 0;
    for (int j = 1; j <= 10; j++) begin
      key_valid = 1'b1;
      key_code  = 4'(j % 10);
      tick();
      if (j <= 9 && senha_real !== pac(4, 4'h1, 4'h2, 4'h3, 4'h4)) estavel = 1'b0;
      if (acesso_negado && primeiro == 0) primeiro = j;
    end
    key_valid = 1'b0;
    check("ocupado buffer estavel", estavel, 1);
    check("espera ciclo do negado", primeiro, 9);
    check("ocupado teclas descartadas", n_digitos, 0);
    check("espera contagem negado", n_neg - neg0, 1);
    check("espera sem acesso_ok", n_ok - ok0, 0);

    // reset while waiting, late done ignored
    ok0 = n_ok; neg0 = n_neg;
    press(4'h1);
    press(TECLA_ENVIA);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst espera ocupado", ocupado, 0);
    check("rst espera n_digitos", n_digitos, 0);
    check("rst espera buffer", senha_real, SENHA_VAZIA);
    done = 1'b1; senha_ok = 1'b1;
    tick();
    done = 1'b0; senha_ok = 1'b0;
    repeat (3) tick();
    check("rst espera sem pulsos", (n_ok - ok0) + (n_neg - neg0), 0);
    check("rst espera ocupado final", ocupado, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
